// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe_pkg / alu_pipe
//
// Elastic, multi-stage integer ALU function unit. One op per cycle is accepted
// from the reservation station and computed combinationally on the way into
// stage 0. The result and its PRF destination tag then travel through STAGES
// pipeline registers. The last stage, STAGES-1, drives the CDB-facing outputs.
//
// Handshake:
//   Input side: an op is transferred at a rising edge when en && ready.
//   ready is a function of the stage valid bits, broadcasted and clear only.
//   It never depends on en in the same cycle, so there is no combinational
//   loop with the RS.
//   Output side: the op in the output stage retires at a rising edge when
//   valid && broadcasted. broadcasted while valid=0 has no effect. While
//   valid=1 and broadcasted=0, result, dest_tag_out and dest_tag_wr_en_out
//   are held stable.
//
// Parameters:
//   WIDTH           operand/result width (power of two, >= 8)
//   STAGES          number of pipeline registers (1..8)
//   PHYS_REG_WIDTH  destination tag width
//
// Ports:
//   clock               rising-edge clock
//   reset_n             asynchronous active-low reset
//   clear               synchronous flush of every in-flight op
//   en                  an op is offered on the inputs this cycle
//   rs1, rs2            operands
//   alu_func            operation select (alu_pipe_pkg encodings)
//   dest_tag_in         PRF destination tag of the offered op
//   dest_tag_wr_en_in   PRF write enable of the offered op
//   broadcasted         the CDB took the current result this cycle
//   ready               an op offered with en is accepted at the next edge
//   valid               output-stage valid bit
//   result              output-stage result
//   dest_tag_out        output-stage tag
//   dest_tag_wr_en_out  output-stage PRF write enable
//   occupancy           number of valid stages
// -----------------------------------------------------------------------------

package alu_pipe_pkg;

  typedef logic [3:0] alu_func_t;

  localparam alu_func_t ALU_ADD  = 4'd0;
  localparam alu_func_t ALU_SUB  = 4'd1;
  localparam alu_func_t ALU_AND  = 4'd2;
  localparam alu_func_t ALU_OR   = 4'd3;
  localparam alu_func_t ALU_XOR  = 4'd4;
  localparam alu_func_t ALU_SLT  = 4'd5;
  localparam alu_func_t ALU_SLTU = 4'd6;
  localparam alu_func_t ALU_SLL  = 4'd7;
  localparam alu_func_t ALU_SRL  = 4'd8;
  localparam alu_func_t ALU_SRA  = 4'd9;

endpackage

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int STAGES         = 3,
  parameter int PHYS_REG_WIDTH = 6
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             en,
  input  logic [WIDTH-1:0]                 rs1,
  input  logic [WIDTH-1:0]                 rs2,
  input  alu_func_t                        alu_func,
  input  logic [PHYS_REG_WIDTH-1:0]        dest_tag_in,
  input  logic                             dest_tag_wr_en_in,
  input  logic                             broadcasted,
  output logic                             ready,
  output logic                             valid,
  output logic [WIDTH-1:0]                 result,
  output logic [PHYS_REG_WIDTH-1:0]        dest_tag_out,
  output logic                             dest_tag_wr_en_out,
  output logic [$clog2(STAGES+1)-1:0]      occupancy
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int OCC_W = $clog2(STAGES+1);

  // Result for unsupported encodings: 0xDEADBEEF repeated and cut to WIDTH.
  function automatic logic [WIDTH-1:0] fill_pattern();
    logic [31:0]      pat;
    logic [WIDTH-1:0] f;
    pat = 32'hDEAD_BEEF;
    f   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f[i] = pat[i[4:0]];
    end
    return f;
  endfunction

  localparam logic [WIDTH-1:0] FILL = fill_pattern();

  // ---------------------------------------------------------------------------
  // Stage 0 input: combinational ALU
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_result;

  assign shamt = rs2[SHW-1:0];

  always_comb begin
    alu_result = FILL;
    case (alu_func)
      ALU_ADD:  alu_result = rs1 + rs2;
      ALU_SUB:  alu_result = rs1 - rs2;
      ALU_AND:  alu_result = rs1 & rs2;
      ALU_OR:   alu_result = rs1 | rs2;
      ALU_XOR:  alu_result = rs1 ^ rs2;
      ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
      ALU_SLL:  alu_result = rs1 << shamt;
      ALU_SRL:  alu_result = rs1 >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(rs1) >>> shamt);
      default:  alu_result = FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline state. Only the valid bits are control state; the data, tag and
  // wr_en registers simply follow whenever their stage advances.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0]         stage_valid;
  logic [STAGES-1:0]         stage_wr_en;
  logic [WIDTH-1:0]          stage_data [STAGES];
  logic [PHYS_REG_WIDTH-1:0] stage_tag  [STAGES];

  logic [STAGES-1:0] adv;
  logic              full_tail;
  logic              load_op;

  // adv[k] means stage k can take new contents this edge. The nominal form is
  // the chain adv[k] = ~valid[k] | adv[k+1]; unrolled, it says stage k may
  // advance unless it and every stage downstream of it are full with the
  // output stalled. Computing it from a running AND keeps the logic free of a
  // self-referencing vector while giving the same bubble-collapsing behaviour.
  always_comb begin
    adv       = '0;
    full_tail = 1'b1;
    for (int k = STAGES-1; k >= 0; k--) begin
      full_tail = full_tail & stage_valid[k];
      adv[k]    = ~full_tail | broadcasted;
    end
  end

  assign ready   = adv[0] & ~clear;
  assign load_op = ready & en;

  // Valid bits: clear beats everything; stage 0 takes en (a bubble when en=0).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= '0;
    end else if (clear) begin
      stage_valid <= '0;
    end else begin
      if (adv[0]) begin
        stage_valid[0] <= en;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          stage_valid[k] <= stage_valid[k-1];
        end
      end
    end
  end

  // Payload registers: stage 0 only loads on an accepted op, so a bubble
  // leaves the previous payload in place.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_wr_en <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_data[k] <= '0;
        stage_tag[k]  <= '0;
      end
    end else begin
      if (load_op) begin
        stage_data[0]  <= alu_result;
        stage_tag[0]   <= dest_tag_in;
        stage_wr_en[0] <= dest_tag_wr_en_in;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          stage_data[k]  <= stage_data[k-1];
          stage_tag[k]   <= stage_tag[k-1];
          stage_wr_en[k] <= stage_wr_en[k-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign valid              = stage_valid[STAGES-1];
  assign result             = stage_data[STAGES-1];
  assign dest_tag_out       = stage_tag[STAGES-1];
  assign dest_tag_wr_en_out = stage_wr_en[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(stage_valid[k]);
    end
  end

endmodule
